// File: rtl/eeprom_reader.sv
// I2C random-read master for 24-series EEPROMs: dummy write of the 15-bit address,
// repeated START, sequential read of num_bytes bytes, then STOP.
module eeprom_reader #(
  parameter int unsigned QTR      = 50,
  parameter logic [2:0]  DEV_ADDR = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [14:0] start_addr,
  input  logic [15:0] num_bytes,
  output logic        SCL,
  output logic        sda_oe,
  input  logic        sda_in,
  output logic [7:0]  read_data,
  output logic        data_valid,
  output logic        busy,
  output logic        done,
  output logic        nack_err
);

  typedef enum logic [3:0] {
    IDLE, START, CTRL_W, ADDR_HI, ADDR_LO, RSTART, CTRL_R, READ, MACK, STOP
  } state_t;

  localparam int unsigned CW      = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [7:0]  CTRL_WR = {4'b1010, DEV_ADDR, 1'b0};
  localparam logic [7:0]  CTRL_RD = {4'b1010, DEV_ADDR, 1'b1};

  state_t        state_q, state_d;
  logic [CW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    q_q, q_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [14:0]   addr_q, addr_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          pre_q, pre_d;
  logic          scl_q, scl_d;
  logic          oe_q, oe_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          dv_q, dv_d;
  logic          done_q, done_d;
  logic          nack_q, nack_d;
  logic          tick;
  logic          is_wr;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    scl_d   = scl_q;
    oe_d    = oe_q;
    rdata_d = rdata_q;
    nack_d  = nack_q;
    dv_d    = 1'b0;
    done_d  = 1'b0;

    tick   = (state_q != IDLE) && (qcnt_q == CW'(QTR - 1));
    qcnt_d = (state_q == IDLE || tick) ? '0 : qcnt_q + CW'(1);
    is_wr  = (state_q == CTRL_W) || (state_q == ADDR_HI) ||
             (state_q == ADDR_LO) || (state_q == CTRL_R);

    if (state_q == IDLE) begin
      if (start) begin
        // pre_q holds idle bus levels for the first QTR clocks before START Q0
        state_d = START;
        pre_d   = 1'b1;
        q_d     = '0;
        bit_d   = '0;
        addr_d  = start_addr;
        cnt_d   = (num_bytes == '0) ? 16'd1 : num_bytes;
        nack_d  = 1'b0;
      end
    end else if (tick) begin
      if (pre_q) begin
        pre_d = 1'b0;
      end else if (q_q != 2'd3) begin
        q_d = q_q + 2'd1;
        if (q_q == 2'd2) begin
          if (is_wr && bit_q == 4'd8 && sda_in) nack_d = 1'b1;
          if (state_q == READ) begin
            sh_d = {sh_q[6:0], sda_in};
            if (bit_q == 4'd7) begin
              rdata_d = {sh_q[6:0], sda_in};
              dv_d    = 1'b1;
            end
          end
        end
      end else begin
        q_d   = '0;
        bit_d = '0;
        unique case (state_q)
          START:  begin state_d = CTRL_W; sh_d = CTRL_WR; end
          CTRL_W, ADDR_HI, ADDR_LO, CTRL_R: begin
            if (bit_q != 4'd8) begin
              bit_d = bit_q + 4'd1;
              sh_d  = {sh_q[6:0], 1'b0};
            end else if (nack_q) begin
              state_d = STOP;
            end else if (state_q == CTRL_W) begin
              state_d = ADDR_HI;
              sh_d    = {1'b0, addr_q[14:8]};
            end else if (state_q == ADDR_HI) begin
              state_d = ADDR_LO;
              sh_d    = addr_q[7:0];
            end else if (state_q == ADDR_LO) begin
              state_d = RSTART;
            end else begin
              state_d = READ;
            end
          end
          RSTART: begin state_d = CTRL_R; sh_d = CTRL_RD; end
          READ: begin
            if (bit_q != 4'd7) bit_d = bit_q + 4'd1;
            else state_d = MACK;
          end
          MACK: begin
            if (cnt_q > 16'd1) begin
              cnt_d   = cnt_q - 16'd1;
              state_d = READ;
            end else begin
              state_d = STOP;
            end
          end
          STOP: begin state_d = IDLE; done_d = 1'b1; end
          default: state_d = IDLE;
        endcase
      end
    end

    // Bus levels are registered for the quarter being entered
    if (state_d == IDLE) begin
      scl_d = 1'b1;
      oe_d  = 1'b0;
    end else if (tick) begin
      unique case (state_d)
        START:  begin scl_d = (q_d != 2'd3); oe_d = q_d[1]; end
        RSTART: begin scl_d = (q_d == 2'd1) || (q_d == 2'd2); oe_d = q_d[1]; end
        STOP:   begin scl_d = (q_d != 2'd0); oe_d = (q_d != 2'd3); end
        default: begin
          scl_d = q_d[1];
          if (q_d == 2'd0) begin
            if (state_d == READ)       oe_d = 1'b0;
            else if (state_d == MACK)  oe_d = (cnt_q > 16'd1);
            else if (bit_d == 4'd8)    oe_d = 1'b0;
            else                       oe_d = ~sh_d[7];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      qcnt_q  <= '0;
      q_q     <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      pre_q   <= 1'b0;
      scl_q   <= 1'b1;
      oe_q    <= 1'b0;
      rdata_q <= '0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      q_q     <= q_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      scl_q   <= scl_d;
      oe_q    <= oe_d;
      rdata_q <= rdata_d;
      dv_q    <= dv_d;
      done_q  <= done_d;
      nack_q  <= nack_d;
    end
  end

  assign SCL        = scl_q;
  assign sda_oe     = oe_q;
  assign read_data  = rdata_q;
  assign data_valid = dv_q;
  assign done       = done_q;
  assign nack_err   = nack_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_eeprom_reader.sv
// Directed bench for eeprom_reader with a behavioural I2C EEPROM slave on the bus.
module tb_eeprom_reader;

  localparam int QTR = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [14:0] start_addr;
  logic [15:0] num_bytes;
  logic        SCL;
  logic        sda_oe;
  logic        sda_line;
  logic [7:0]  read_data;
  logic        data_valid;
  logic        busy;
  logic        done;
  logic        nack_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  eeprom_reader #(.QTR(QTR), .DEV_ADDR(3'b000)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .num_bytes(num_bytes), .SCL(SCL), .sda_oe(sda_oe), .sda_in(sda_line),
    .read_data(read_data), .data_valid(data_valid), .busy(busy),
    .done(done), .nack_err(nack_err)
  );

  // Slave model: address 1010_000, 32K x 8 memory
  logic [7:0]  mem [0:32767];
  logic        slv_pull = 1'b0;
  logic        nack_ctrl = 1'b0;
  logic        prev_scl = 1'b1, prev_sda = 1'b1;
  int          bitcnt = 0, bidx = 0;
  bit          tx = 0, in_ack = 0, acked = 0;
  logic [7:0]  sh = '0, ctrl = '0, bt;
  logic [14:0] ptr = '0;
  logic [7:0]  rx_bytes [$];
  logic        macks [$];
  int          starts = 0, stops = 0;

  assign sda_line = ~(sda_oe | slv_pull);

  always begin
    logic cs, cd;
    @(posedge clk);
    #2;
    cs = SCL;
    cd = sda_line;
    if (cs && prev_scl && prev_sda && !cd) begin
      starts++;
      bitcnt = 0; bidx = 0; tx = 0; in_ack = 0; slv_pull = 1'b0;
    end else if (cs && prev_scl && !prev_sda && cd) begin
      stops++;
      bitcnt = 0; bidx = 0; tx = 0; in_ack = 0; slv_pull = 1'b0;
    end else if (cs && !prev_scl) begin
      if (!tx) begin
        if (!in_ack && bitcnt < 8) begin
          sh = {sh[6:0], cd};
          bitcnt++;
        end
      end else if (bitcnt < 8) begin
        bitcnt++;
      end else if (bitcnt == 8) begin
        macks.push_back(cd);
        if (cd) begin tx = 0; bitcnt = 0; bidx = 99; end
        else begin ptr = ptr + 15'd1; bitcnt = 9; end
      end
    end else if (!cs && prev_scl) begin
      if (!tx) begin
        if (in_ack) begin
          in_ack = 0; slv_pull = 1'b0; bitcnt = 0;
          if (bidx == 1 && ctrl[0] && acked) begin
            tx = 1; bt = mem[ptr]; slv_pull = ~bt[7];
          end
        end else if (bitcnt == 8) begin
          in_ack = 1;
          rx_bytes.push_back(sh);
          acked = 1;
          if (bidx == 0) begin
            ctrl  = sh;
            acked = (sh[7:1] == 7'h50) && !nack_ctrl;
          end else if (bidx == 1) begin
            ptr[14:8] = sh[6:0];
          end else if (bidx == 2) begin
            ptr[7:0] = sh;
          end
          slv_pull = acked;
          bidx++;
        end
      end else begin
        bt = mem[ptr];
        if (bitcnt >= 1 && bitcnt <= 7) slv_pull = ~bt[3'(7 - bitcnt)];
        else if (bitcnt == 8) slv_pull = 1'b0;
        else if (bitcnt == 9) begin bitcnt = 0; slv_pull = ~bt[7]; end
      end
    end
    prev_scl = cs;
    prev_sda = cd;
  end

  // Output monitor
  logic [7:0] dv_data [$];
  int         phases [$];
  int         done_cnt = 0, pcnt = 0, oe_rise_hi = 0, oe_fall_hi = 0;
  logic       m_scl = 1'b1, m_oe = 1'b0;

  always begin
    @(posedge clk);
    #1;
    if (data_valid) dv_data.push_back(read_data);
    if (done) done_cnt++;
    if (SCL != m_scl) begin phases.push_back(pcnt); pcnt = 1; end
    else pcnt++;
    if (sda_oe != m_oe && SCL && m_scl) begin
      if (sda_oe) oe_rise_hi++;
      else oe_fall_hi++;
    end
    m_scl = SCL;
    m_oe  = sda_oe;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [14:0] a, input logic [15:0] n);
    @(negedge clk);
    start_addr = a;
    num_bytes  = n;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n  = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done_cnt - d0, 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    int bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (SCL !== 1'b1 || sda_oe !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    int rb, mb, db, sb, pb, ob, fb, dnb, stb, k;
    for (int i = 0; i < 32768; i++) mem[i] = 8'hEE;
    mem[15'h1234] = 8'h5A;
    mem[15'h0010] = 8'h01;
    mem[15'h0011] = 8'h02;
    mem[15'h0012] = 8'h03;
    rst = 1'b0; start = 1'b0; start_addr = '0; num_bytes = '0;

    repeat (3) @(negedge clk);
    chk("rst_scl", SCL, 1);
    chk("rst_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_rdata", read_data, 8'h00);
    chk("rst_nack", nack_err, 0);
    rst = 1'b1;
    check_quiet("idle_quiet");

    // Single-byte read from 0x1234
    rb = rx_bytes.size(); mb = macks.size(); db = dv_data.size(); sb = starts;
    stb = stops; pb = phases.size(); ob = oe_rise_hi; fb = oe_fall_hi; dnb = done_cnt;
    do_start(15'h1234, 16'd1);
    chk("t1_busy", busy, 1);
    k = 0;
    while (!sda_oe && k < 1000) begin @(negedge clk); k++; end
    chk("t1_start_lat", k, 3 * QTR);
    wait_done("t1_done", 20000);
    chk("t1_b0", rx_bytes[rb], 8'hA0);
    chk("t1_b1", rx_bytes[rb+1], 8'h12);
    chk("t1_b2", rx_bytes[rb+2], 8'h34);
    chk("t1_b3", rx_bytes[rb+3], 8'hA1);
    chk("t1_nbytes", rx_bytes.size() - rb, 4);
    chk("t1_starts", starts - sb, 2);
    chk("t1_stops", stops - stb, 1);
    chk("t1_dv_cnt", dv_data.size() - db, 1);
    chk("t1_dv_data", dv_data[db], 8'h5A);
    chk("t1_rdata", read_data, 8'h5A);
    chk("t1_mack_cnt", macks.size() - mb, 1);
    chk("t1_mnack", macks[mb], 1);
    chk("t1_done_cnt", done_cnt - dnb, 1);
    chk("t1_nack", nack_err, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_scl_hi", phases[pb+2], 2 * QTR);
    chk("t1_scl_lo", phases[pb+3], 2 * QTR);
    chk("t1_oe_rise_hi", oe_rise_hi - ob, 2);
    chk("t1_oe_fall_hi", oe_fall_hi - fb, 1);

    // Three-byte sequential read from 0x0010
    mb = macks.size(); db = dv_data.size(); stb = stops; dnb = done_cnt;
    do_start(15'h0010, 16'd3);
    wait_done("t2_done", 30000);
    chk("t2_dv_cnt", dv_data.size() - db, 3);
    chk("t2_d0", dv_data[db], 8'h01);
    chk("t2_d1", dv_data[db+1], 8'h02);
    chk("t2_d2", dv_data[db+2], 8'h03);
    chk("t2_mack0", macks[mb], 0);
    chk("t2_mack1", macks[mb+1], 0);
    chk("t2_mack2", macks[mb+2], 1);
    chk("t2_stops", stops - stb, 1);
    chk("t2_done_cnt", done_cnt - dnb, 1);

    // Slave NACKs the control byte
    nack_ctrl = 1'b1;
    rb = rx_bytes.size(); db = dv_data.size(); stb = stops;
    do_start(15'h1234, 16'd2);
    wait_done("t3_done", 20000);
    nack_ctrl = 1'b0;
    chk("t3_nack", nack_err, 1);
    chk("t3_dv_cnt", dv_data.size() - db, 0);
    chk("t3_nbytes", rx_bytes.size() - rb, 1);
    chk("t3_stops", stops - stb, 1);
    chk("t3_busy", busy, 0);
    chk("t3_rdata_held", read_data, 8'h03);

    // num_bytes=0 reads one byte; a second start while busy is ignored
    rb = rx_bytes.size(); db = dv_data.size(); stb = stops; dnb = done_cnt; sb = starts;
    do_start(15'h1234, 16'd0);
    chk("t5_nack_clr", nack_err, 0);
    repeat (20) @(negedge clk);
    do_start(15'h0010, 16'd5);
    wait_done("t5_done", 20000);
    repeat (400) @(negedge clk);
    chk("t5_dv_cnt", dv_data.size() - db, 1);
    chk("t5_dv_data", dv_data[db], 8'h5A);
    chk("t5_b1", rx_bytes[rb+1], 8'h12);
    chk("t5_b2", rx_bytes[rb+2], 8'h34);
    chk("t5_starts", starts - sb, 2);
    chk("t5_stops", stops - stb, 1);
    chk("t5_done_cnt", done_cnt - dnb, 1);
    chk("t5_busy", busy, 0);

    // Reset during the 2nd data bit of ADDR_LO (SCL low, SDA pulled)
    do_start(15'h1234, 16'd1);
    k = 0;
    while (!(bidx == 2 && bitcnt == 1 && !in_ack && SCL == 1'b0) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk("t4_reached", (k < 20000), 1);
    chk("t4_pre_oe", sda_oe, 1);
    rst = 1'b0;
    #1;
    chk("t4_scl", SCL, 1);
    chk("t4_oe", sda_oe, 0);
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_dv", data_valid, 0);
    chk("t4_rdata", read_data, 8'h00);
    chk("t4_nack", nack_err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check_quiet("t4_quiet");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
